arm_pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the ARM core. It centralises the per-stage enable, valid and flush logic that is currently spread across the IF/ID/EXE/MEM/WB stage registers. It generalises the fixed five-stage scheme to NUM_STAGES stages and adds memory wait-state stalls, per-stage valid tracking, and saturating performance counters. It sits beside the stage registers, driving their enables and flushes, and takes hazard, branch and memory-busy events as inputs.

---
 rtl/arm_pipe_pkg.sv | 22 ++
 rtl/arm_pipe_ctrl_if.sv | 38 +++
 rtl/arm_sat_counter.sv | 23 ++
 rtl/arm_pipe_ctrl.sv | 102 ++++++++++
 tb/tb_arm_pipe_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and event encoding for the ARM pipeline control
// Purpose: stage index constants, default counter width and the event priority
//          encoding used by arm_pipe_ctrl and its interface.
package arm_pipe_pkg;

  localparam int IF_S      = 0;
  localparam int ID_S      = 1;
  localparam int EXE_S     = 2;
  localparam int MEM_S     = 3;
  localparam int WB_S      = 4;

  localparam int DEF_CNT_W = 32;

  // Encoded winner of the per-cycle event arbitration (rst handled separately).
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_HAZ  = 2'd1,
    EV_BR   = 2'd2,
    EV_MEM  = 2'd3
  } pipe_ev_e;

endpackage

// File: rtl/arm_pipe_ctrl_if.sv
// rtl/arm_pipe_ctrl_if.sv - event inputs, stage controls and counters of arm_pipe_ctrl
// Purpose: bundles the pipeline-control signals between the controller and the stage datapath.
// Ports (per modport):
//   master (controller): in  hazard, branch_taken, mem_busy
//                        out stage_en, stage_valid, pc_en, pc_sel_br,
//                            retired_cnt, stall_cnt, flush_cnt
//   slave  (datapath)  : mirror image of master
interface arm_pipe_ctrl_if
  import arm_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                  hazard;
  logic                  branch_taken;
  logic                  mem_busy;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  pc_en;
  logic                  pc_sel_br;
  logic [CNT_W-1:0]      retired_cnt;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    input  hazard, branch_taken, mem_busy,
    output stage_en, stage_valid, pc_en, pc_sel_br,
           retired_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output hazard, branch_taken, mem_busy,
    input  stage_en, stage_valid, pc_en, pc_sel_br,
           retired_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/arm_sat_counter.sv
// rtl/arm_sat_counter.sv - width-parametrised saturating up-counter with synchronous clear
// Purpose: counts cycles where inc is high, sticking at all-ones instead of wrapping.
// Ports: clk in, clr in (synchronous clear, wins over inc), inc in, count out [W-1:0]
module arm_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// rtl/arm_pipe_ctrl.sv - pipeline enable/valid/flush control with stall and flush counters
// Purpose: arbitrates memory-busy, taken-branch and data-hazard events, drives per-stage
//          load enables and PC control combinationally, tracks per-stage valid bits and
//          keeps saturating retired/stall/flush counters.
// Ports: clk in, rst in (synchronous, active-high),
//        pif  arm_pipe_ctrl_if.master (events in; stage_en, stage_valid, pc_en,
//             pc_sel_br and counters out)
module arm_pipe_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int HAZ_STAGE  = ID_S,
  parameter int BR_STAGE   = EXE_S,
  parameter int MEM_STAGE  = MEM_S,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  arm_pipe_ctrl_if.master        pif
);

  // Stages frozen by each stall kind, and stages squashed by a taken branch (IF refetches).
  localparam logic [NUM_STAGES-1:0] MEM_FREEZE = NUM_STAGES'((1 << (MEM_STAGE + 1)) - 1);
  localparam logic [NUM_STAGES-1:0] HAZ_FREEZE = NUM_STAGES'((1 << (HAZ_STAGE + 1)) - 1);
  localparam logic [NUM_STAGES-1:0] BR_SQUASH  = NUM_STAGES'(((1 << (BR_STAGE + 1)) - 1) & ~1);
  localparam logic [NUM_STAGES-1:0] VALID_RST  = NUM_STAGES'(1);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] shifted;
  logic                  hz;
  logic                  br;
  logic                  mb;
  pipe_ev_e              ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= VALID_RST;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_comb begin
    hz      = pif.hazard       & valid_q[HAZ_STAGE];
    br      = pif.branch_taken & valid_q[BR_STAGE];
    mb      = pif.mem_busy     & valid_q[MEM_STAGE];

    ev      = EV_NONE;
    if (mb) begin
      ev = EV_MEM;
    end else if (br) begin
      ev = EV_BR;
    end else if (hz) begin
      ev = EV_HAZ;
    end

    en = '1;
    if (!rst) begin
      case (ev)
        EV_MEM:  en = ~MEM_FREEZE;
        EV_HAZ:  en = ~HAZ_FREEZE;
        default: en = '1;
      endcase
    end

    // A stage whose upstream neighbour is frozen receives a bubble rather than a copy.
    shifted = {valid_q[NUM_STAGES-2:0] & en[NUM_STAGES-2:0], 1'b1};
    valid_d = (en & shifted) | (~en & valid_q);
    if (ev == EV_BR) begin
      valid_d = valid_d & ~BR_SQUASH;
    end
  end

  assign pif.stage_en    = en;
  assign pif.pc_en       = en[0];
  assign pif.pc_sel_br   = !rst && (ev == EV_BR);
  assign pif.stage_valid = valid_q;

  arm_sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (valid_q[NUM_STAGES-1]),
    .count (pif.retired_cnt)
  );

  arm_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   ((ev == EV_MEM) || (ev == EV_HAZ)),
    .count (pif.stall_cnt)
  );

  arm_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (ev == EV_BR),
    .count (pif.flush_cnt)
  );

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// tb/tb_arm_pipe_ctrl.sv - self-checking bench for arm_pipe_ctrl against an instruction-slot model
module tb_arm_pipe_ctrl;
  import arm_pipe_pkg::*;

  localparam int NS  = 5;
  localparam int HAZ = ID_S;
  localparam int BR  = EXE_S;
  localparam int MEM = MEM_S;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  arm_pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_W(32)) pif ();
  arm_pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_W(4))  pif4 ();

  assign pif4.hazard       = pif.hazard;
  assign pif4.branch_taken = pif.branch_taken;
  assign pif4.mem_busy     = pif.mem_busy;

  arm_pipe_ctrl #(
    .NUM_STAGES(NS), .HAZ_STAGE(HAZ), .BR_STAGE(BR), .MEM_STAGE(MEM), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  arm_pipe_ctrl #(
    .NUM_STAGES(NS), .HAZ_STAGE(HAZ), .BR_STAGE(BR), .MEM_STAGE(MEM), .CNT_W(4)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .pif (pif4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: each stage holds an instruction id (0 = bubble).
  int     slot [NS];
  int     next_id;
  longint m_ret;
  longint m_stall;
  longint m_flush;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) slot[k] = 0;
    next_id++;
    slot[0] = next_id;
    m_ret   = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One clock: apply inputs, compare against the model, advance the model, take the edge.
  task automatic cycle(input logic h, input logic b, input logic m, input logic r);
    bit              mb, br, hz, sel;
    int              fz;
    logic [NS-1:0]   e_en;
    logic [NS-1:0]   e_val;
    @(negedge clk);
    pif.hazard       = h;
    pif.branch_taken = b;
    pif.mem_busy     = m;
    rst              = r;
    #1;
    mb  = m && (slot[MEM] != 0);
    br  = b && (slot[BR] != 0) && !mb;
    hz  = h && (slot[HAZ] != 0) && !mb && !br;
    fz  = r ? -1 : (mb ? MEM : (hz ? HAZ : -1));
    sel = br && !r;
    for (int k = 0; k < NS; k++) begin
      e_en[k]  = (k > fz);
      e_val[k] = (slot[k] != 0);
    end
    check("stage_en",     64'(pif.stage_en),    64'(e_en));
    check("pc_en",        64'(pif.pc_en),       64'(e_en[0]));
    check("pc_sel_br",    64'(pif.pc_sel_br),   64'(sel));
    check("stage_valid",  64'(pif.stage_valid), 64'(e_val));
    check("retired_cnt",  64'(pif.retired_cnt), 64'(m_ret));
    check("stall_cnt",    64'(pif.stall_cnt),   64'(m_stall));
    check("flush_cnt",    64'(pif.flush_cnt),   64'(m_flush));
    check("retired_cnt4", 64'(pif4.retired_cnt), 64'(sat4(m_ret)));
    check("stall_cnt4",   64'(pif4.stall_cnt),   64'(sat4(m_stall)));
    check("flush_cnt4",   64'(pif4.flush_cnt),   64'(sat4(m_flush)));
    if (r) begin
      model_reset();
    end else begin
      if (slot[NS-1] != 0) m_ret++;
      if (mb || hz) m_stall++;
      if (br) m_flush++;
      for (int k = NS - 1; k > fz; k--) begin
        if (k == 0) begin
          next_id++;
          slot[0] = next_id;
        end else if (k - 1 == fz) begin
          slot[k] = 0;
        end else begin
          slot[k] = slot[k-1];
        end
      end
      if (br) for (int k = 1; k <= BR; k++) slot[k] = 0;
    end
    @(posedge clk);
  endtask

  initial begin
    pif.hazard       = 1'b0;
    pif.branch_taken = 1'b0;
    pif.mem_busy     = 1'b0;
    next_id          = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Fill after reset.
    repeat (10) cycle(0, 0, 0, 0);
    #2;
    check("fill_valid",   64'(pif.stage_valid), 64'(5'b11111));
    check("fill_retired", 64'(pif.retired_cnt), 64'd6);
    check("fill_stall",   64'(pif.stall_cnt),   64'd0);

    // Two-cycle hazard with ID valid.
    repeat (2) cycle(1, 0, 0, 0);
    #2;
    check("haz_valid", 64'(pif.stage_valid), 64'(5'b10011));
    check("haz_stall", 64'(pif.stall_cnt),   64'd2);

    // Taken branch with EXE valid.
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    #2;
    check("br_valid", 64'(pif.stage_valid), 64'(5'b11001));
    check("br_flush", 64'(pif.flush_cnt),   64'd1);

    // Memory wait of 3 cycles with a branch pending in EXE.
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 1, 1, 0);
    #2;
    check("mem_valid", 64'(pif.stage_valid), 64'(5'b01111));
    check("mem_flush", 64'(pif.flush_cnt),   64'd1);
    cycle(0, 1, 0, 0);
    #2;
    check("mem_br_valid", 64'(pif.stage_valid), 64'(5'b11001));
    check("mem_stall",    64'(pif.stall_cnt),   64'd5);
    check("mem_br_flush", 64'(pif.flush_cnt),   64'd2);

    // Hazard and branch together: branch wins.
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    #2;
    check("hb_valid", 64'(pif.stage_valid), 64'(5'b11001));
    check("hb_stall", 64'(pif.stall_cnt),   64'd5);
    check("hb_flush", 64'(pif.flush_cnt),   64'd3);

    // Saturation on the narrow counters, then reset in the middle of a memory stall.
    cycle(0, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);
    #2;
    check("sat_retired4", 64'(pif4.retired_cnt), 64'd15);
    check("sat_retired",  64'(pif.retired_cnt),  64'd16);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    #2;
    check("rst_valid",    64'(pif.stage_valid),  64'(5'b00001));
    check("rst_retired4", 64'(pif4.retired_cnt), 64'd0);
    check("rst_stall4",   64'(pif4.stall_cnt),   64'd0);
    check("rst_stall",    64'(pif.stall_cnt),    64'd0);
    cycle(0, 0, 1, 0);
    #2;
    check("post_rst_valid", 64'(pif.stage_valid), 64'(5'b00011));

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 99) < 30),
            logic'($urandom_range(0, 99) < 20),
            logic'($urandom_range(0, 99) < 25),
            logic'($urandom_range(0, 99) < 2));
    end
    cycle(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
